// File: rtl/fp32_vector16_loader.sv
// Streaming loader for the 16-lane FP32 dot-product unit.
// It assembles two 16-element vectors from a valid/ready stream of operand
// pairs. It holds the vectors for DP_LATENCY cycles, then captures dp_result
// and offers it on a valid/ready result stream.
// Optional feature macro FP32_LOADER_ZERO_PAD_EN: in_last ends a short vector,
// and the remaining lanes are padded with +0.0.
module fp32_vector16_loader #(
   parameter int unsigned DP_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_a,
   input  logic [31:0]  in_b,
   input  logic         in_last,
   output logic [511:0] vec_a_flat,
   output logic [511:0] vec_b_flat,
   output logic         dp_start,
   input  logic [31:0]  dp_result,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [31:0]  res_data
);

   localparam int unsigned LANES = 16;
   localparam int unsigned EW    = 32;
   localparam int unsigned IW    = 4;
   localparam int unsigned CW    = 4;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;

   logic accept_c;
   logic final_c;
   logic last_c;
   logic pad_c;
   logic capture_c;
   logic release_c;

`ifdef FP32_LOADER_ZERO_PAD_EN
   assign last_c = in_last;
`else
   logic unused_in_last;
   assign unused_in_last = in_last;
   assign last_c         = 1'b0;
`endif

   assign pad_c = accept_c & last_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FILL;
      else        state <= state_nx;
   end

   // Next-state decode and per-cycle strobes
   always_comb begin
      state_nx  = state;
      accept_c  = 1'b0;
      final_c   = 1'b0;
      capture_c = 1'b0;
      release_c = 1'b0;
      case (state)
         S_FILL: begin
            accept_c = in_valid & in_ready;
            if (accept_c && ((idx == IW'(LANES - 1)) || last_c)) begin
               final_c  = 1'b1;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt <= CW'(1)) begin
               capture_c = 1'b1;
               state_nx  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               release_c = 1'b1;
               state_nx  = S_FILL;
            end
         end
         default: state_nx = S_FILL;
      endcase
   end

   // Control registers: lane index, wait counter, handshake flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         dp_start  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         in_ready <= (state_nx == S_FILL);
         dp_start <= final_c;
         if (final_c)       idx <= '0;
         else if (accept_c) idx <= idx + IW'(1);
         if (final_c)                cnt <= CW'(DP_LATENCY);
         else if (capture_c)         cnt <= '0;
         else if (state == S_WAIT)   cnt <= cnt - CW'(1);
         if (capture_c) begin
            res_data  <= dp_result;
            res_valid <= 1'b1;
         end else if (release_c) begin
            res_valid <= 1'b0;
         end
      end
   end

   // Vector lanes: bit-exact store of accepted pairs, optional zero fill of the tail
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_a_flat <= '0;
         vec_b_flat <= '0;
      end else if (accept_c) begin
         if (pad_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (i > 32'(idx)) begin
                  vec_a_flat[i*EW +: EW] <= '0;
                  vec_b_flat[i*EW +: EW] <= '0;
               end
            end
         end
         vec_a_flat[32'(idx)*EW +: EW] <= in_a;
         vec_b_flat[32'(idx)*EW +: EW] <= in_b;
      end
   end

endmodule

// File: tb/tb_fp32_vector16_loader.sv
// Bench for fp32_vector16_loader: a behavioural dot-product model drives
// dp_result, and vectors plus corner sequences are checked against
// hand-computed FP32 results.
module tb_fp32_vector16_loader;

   localparam int DP_LAT = 3;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_a;
   logic [31:0]  in_b;
   logic         in_last;
   logic [511:0] vec_a_flat;
   logic [511:0] vec_b_flat;
   logic         dp_start;
   logic [31:0]  dp_result;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  res_data;

   int n_pass;
   int n_total;
   int cyc;
   int dp_cnt;
   int hs_cyc;

   typedef struct {
      string       name;
      real         a0;
      real         astep;
      real         b0;
      real         bstep;
      int          n;
      bit          gaps;
      int          hold;
      bit          b2b;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[5];

   fp32_vector16_loader #(.DP_LATENCY(DP_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_last    (in_last),
      .vec_a_flat (vec_a_flat),
      .vec_b_flat (vec_b_flat),
      .dp_start   (dp_start),
      .dp_result  (dp_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (dp_start) dp_cnt <= dp_cnt + 1;

   // Exact for the normal/zero values used here
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (r == 0.0) return 32'h0;
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic real f2r(input logic [31:0] f);
      if (f[30:23] == 8'd0) return 0.0;
      return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] dot(input logic [511:0] va, input logic [511:0] vb);
      real s;
      s = 0.0;
      for (int i = 0; i < 16; i++) s = s + f2r(va[32*i +: 32]) * f2r(vb[32*i +: 32]);
      return r2f(s);
   endfunction

   assign dp_result = dot(vec_a_flat, vec_b_flat);

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic feed(input real a0, input real astep, input real b0, input real bstep,
                       input int n, input bit last, input bit gaps,
                       output int acc, output int first_cyc, output int last_cyc);
      int guard;
      bit hot;
      bit take;
      acc = 0; guard = 0; hot = 1'b1; first_cyc = -1; last_cyc = -1;
      while (acc < n && guard < 100) begin
         in_valid = gaps ? hot : 1'b1;
         in_a     = r2f(a0 + astep * $itor(acc));
         in_b     = r2f(b0 + bstep * $itor(acc));
         in_last  = last && (acc == n - 1);
         take     = in_valid && in_ready;
         @(posedge clk); #1;
         if (take) begin
            if (acc == 0) first_cyc = cyc;
            last_cyc = cyc;
            acc++;
         end
         hot = ~hot;
         guard++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic finish_vec(input string nm, input int hold, input logic [31:0] exp,
                             input int last_cyc, input int dp0);
      int guard;
      bit ok;
      res_ready = (hold == 0);
      guard = 0;
      while (!res_valid && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      check({nm, "_res_valid"}, 64'(res_valid), 64'd1);
      check({nm, "_latency"}, 64'(cyc - last_cyc), 64'(DP_LAT));
      check({nm, "_res_data"}, 64'(res_data), 64'(exp));
      check({nm, "_dp_start_pulses"}, 64'(dp_cnt - dp0), 64'd1);
      if (hold > 0) begin
         ok = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || res_data !== exp || in_ready !== 1'b0) ok = 1'b0;
         end
         check({nm, "_hold_stable"}, 64'(ok), 64'd1);
         res_ready = 1'b1;
      end
      @(posedge clk); #1;
      hs_cyc = cyc;
      check({nm, "_handshake"}, 64'({res_valid, in_ready}), 64'b01);
   endtask

   initial begin
      int acc;
      int fc;
      int lc;
      int dp0;
      n_pass = 0; n_total = 0; cyc = 0; dp_cnt = 0; hs_cyc = -10;
      tbl[0] = '{"full",  1.0, 1.0, 15.5, -1.0, 16, 1'b0, 0,  1'b0, 32'h443B0000};
      tbl[1] = '{"bkpr",  1.0, 1.0, 15.5, -1.0, 16, 1'b0, 10, 1'b0, 32'h443B0000};
      tbl[2] = '{"gaps",  1.0, 1.0, 15.5, -1.0, 16, 1'b1, 0,  1'b0, 32'h443B0000};
      tbl[3] = '{"b2b_a", 0.5, 0.5, 2.0,  0.0,  16, 1'b0, 0,  1'b1, 32'h43080000};
      tbl[4] = '{"b2b_b", 1.0, 1.0, 15.5, -1.0, 16, 1'b0, 0,  1'b1, 32'h443B0000};

      rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(in_ready), 64'd1);
      check("rst_vec_a",     64'(vec_a_flat == '0), 64'd1);
      check("rst_vec_b",     64'(vec_b_flat == '0), 64'd1);
      check("rst_dp_start",  64'(dp_start), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_data",  64'(res_data), 64'd0);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int t = 0; t < 5; t++) begin
         dp0 = dp_cnt;
         feed(tbl[t].a0, tbl[t].astep, tbl[t].b0, tbl[t].bstep, tbl[t].n, 1'b0, tbl[t].gaps,
              acc, fc, lc);
         check({tbl[t].name, "_accepts"}, 64'(acc), 64'(tbl[t].n));
         if (!tbl[t].gaps) check({tbl[t].name, "_burst"}, 64'(lc - fc), 64'(tbl[t].n - 1));
         if (tbl[t].b2b) check({tbl[t].name, "_restart"}, 64'(fc), 64'(hs_cyc + 1));
         finish_vec(tbl[t].name, tbl[t].hold, tbl[t].exp, lc, dp0);
      end

      // Reset in the middle of a fill
      feed(100.0, 1.0, 3.0, 0.0, 7, 1'b0, 1'b0, acc, fc, lc);
      check("midrst_accepts", 64'(acc), 64'd7);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_in_ready",  64'(in_ready), 64'd1);
      check("midrst_vec_a",     64'(vec_a_flat == '0), 64'd1);
      check("midrst_vec_b",     64'(vec_b_flat == '0), 64'd1);
      check("midrst_dp_start",  64'(dp_start), 64'd0);
      check("midrst_res_valid", 64'(res_valid), 64'd0);
      check("midrst_res_data",  64'(res_data), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dp0 = dp_cnt;
      feed(1.0, 1.0, 15.5, -1.0, 16, 1'b0, 1'b0, acc, fc, lc);
      check("postrst_accepts", 64'(acc), 64'd16);
      finish_vec("postrst", 0, 32'h443B0000, lc, dp0);

      // Short vector terminated with in_last
      dp0 = dp_cnt;
      feed(1.0, 1.0, 1.0, 0.0, 4, 1'b1, 1'b0, acc, fc, lc);
      check("short_accepts", 64'(acc), 64'd4);
`ifdef FP32_LOADER_ZERO_PAD_EN
      finish_vec("zpad", 0, 32'h41200000, lc, dp0);
      check("zpad_tail_a", 64'(vec_a_flat[511:128] == '0), 64'd1);
      check("zpad_tail_b", 64'(vec_b_flat[511:128] == '0), 64'd1);
      check("zpad_lane3_a", 64'(vec_a_flat[127:96]), 64'(r2f(4.0)));
`else
      repeat (5) @(posedge clk);
      #1;
      check("nopad_in_ready",  64'(in_ready), 64'd1);
      check("nopad_res_valid", 64'(res_valid), 64'd0);
      check("nopad_no_start",  64'(dp_cnt - dp0), 64'd0);
      check("nopad_lane4_b",   64'(vec_b_flat[159:128]), 64'(r2f(11.5)));
      feed(5.0, 1.0, 1.0, 0.0, 12, 1'b0, 1'b0, acc, fc, lc);
      check("nopad_rest_accepts", 64'(acc), 64'd12);
      finish_vec("nopad", 0, 32'h43080000, lc, dp0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
